word_mem_responder: RTL

//  Memory-side responder for the CPU data/instruction bus (readM, writeM, address, inout data).

---
 rtl/mem_bus_pkg.sv | 19 +
 rtl/word_mem_responder_if.sv | 31 +++
 rtl/mem_word_array.sv | 36 +++
 rtl/word_mem_responder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the word memory responder: FSM state encoding, operation codes,
// default word width and the width of the latency counter.
package mem_bus_pkg;

   localparam int unsigned WordSizeDef = 16;
   localparam int unsigned LatWidth    = 4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } state_e;

   typedef enum logic {
      OpRd = 1'b0,
      OpWr = 1'b1
   } op_e;

endpackage

// File: rtl/word_mem_responder_if.sv
// Request/response handshake signals between a requester (cpu) and the word memory responder.
// The shared inout data bus is a plain port on the responder.
interface word_mem_responder_if
   import mem_bus_pkg::*;
#(
   parameter int unsigned WORD_SIZE = WordSizeDef
);

   logic                 readM;
   logic                 writeM;
   logic [WORD_SIZE-1:0] address;
   logic                 ready;
   logic                 bus_err;

   modport master (
      output readM,
      output writeM,
      output address,
      input  ready,
      input  bus_err
   );

   modport slave (
      input  readM,
      input  writeM,
      input  address,
      output ready,
      output bus_err
   );

endinterface

// File: rtl/mem_word_array.sv
// Word-wide storage for the responder: synchronous write, registered read, no reset so the
// contents survive a responder reset.
module mem_word_array #(
   parameter int unsigned AddrBits = 8,
   parameter int unsigned WordSize = 16
) (
   input  logic                clk_i,
   input  logic                we_i,
   input  logic                re_i,
   input  logic [AddrBits-1:0] addr_i,
   input  logic [WordSize-1:0] wdata_i,
   output logic [WordSize-1:0] rdata_o
);

   logic [WordSize-1:0] mem_q [2**AddrBits];
   logic [WordSize-1:0] rdata_d, rdata_q;

   // Read data only updates on an explicit read so it stays stable while ready is held.
   always_comb begin
      rdata_d = rdata_q;
      if (re_i) begin
         rdata_d = mem_q[addr_i];
      end
   end

   // Storage write port and read data register.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= rdata_d;
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/word_mem_responder.sv
// Memory-side responder for the cpu bus. Serves one read or write at a time from an internal
// word array after LATENCY clock edges (the accepting edge counts as the first), then holds
// ready until the requester drops its request (four-phase handshake).
// Optional build macro MEM_BUS_CHECK_EN enables the sticky bus_err protocol checker; without
// it bus_err is tied low and the checker is absent.
module word_mem_responder
   import mem_bus_pkg::*;
#(
   parameter int unsigned WORD_SIZE = WordSizeDef,
   parameter int unsigned ADDR_BITS = 8,
   parameter int unsigned LATENCY   = 2
) (
   input  logic                 Clk,
   input  logic                 Reset_N,
   word_mem_responder_if.slave  bus,
   inout  wire  [WORD_SIZE-1:0] data
);

   state_e               state_d, state_q;
   logic [LatWidth-1:0]  cnt_d, cnt_q;
   logic [ADDR_BITS-1:0] addr_d, addr_q;
   op_e                  op_d, op_q;
   logic [WORD_SIZE-1:0] wdata_d, wdata_q;
   logic                 ready_d, ready_q;
   logic                 drive_d, drive_q;
   logic                 commit;
   logic                 mem_we, mem_re;
   logic [WORD_SIZE-1:0] rdata;
   logic [WORD_SIZE-1:0] address;
   logic                 any_req, one_req;

   assign address = bus.address;
   assign any_req = bus.readM | bus.writeM;
   assign one_req = bus.readM ^ bus.writeM;

   // Next-state logic; commit marks the edge on which the FSM enters StResp.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      op_d    = op_q;
      wdata_d = wdata_q;
      ready_d = ready_q;
      drive_d = drive_q;
      commit  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (one_req) begin
               addr_d  = address[ADDR_BITS-1:0];
               op_d    = bus.writeM ? OpWr : OpRd;
               wdata_d = data;
               if (LATENCY == 1) begin
                  state_d = StResp;
                  commit  = 1'b1;
               end else begin
                  state_d = StWait;
                  cnt_d   = LatWidth'(LATENCY - 1);
               end
            end
         end
         StWait: begin
            if (!any_req) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == LatWidth'(1)) begin
               state_d = StResp;
               cnt_d   = '0;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - LatWidth'(1);
            end
         end
         StResp: begin
            if (!any_req) begin
               state_d = StIdle;
               ready_d = 1'b0;
               drive_d = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      if (commit) begin
         ready_d = 1'b1;
         drive_d = (op_d == OpRd);
      end
   end

   // Reset gates the array so an access on a reset edge never commits.
   assign mem_we = commit & Reset_N & (op_d == OpWr);
   assign mem_re = commit & Reset_N & (op_d == OpRd);

   mem_word_array #(
      .AddrBits (ADDR_BITS),
      .WordSize (WORD_SIZE)
   ) u_array (
      .clk_i   (Clk),
      .we_i    (mem_we),
      .re_i    (mem_re),
      .addr_i  (addr_d),
      .wdata_i (wdata_d),
      .rdata_o (rdata)
   );

   // FSM state, request latches and registered handshake outputs.
   always_ff @(posedge Clk) begin
      if (!Reset_N) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= '0;
         op_q    <= OpRd;
         wdata_q <= '0;
         ready_q <= 1'b0;
         drive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
         wdata_q <= wdata_d;
         ready_q <= ready_d;
         drive_q <= drive_d;
      end
   end

   assign bus.ready = ready_q;
   assign data      = drive_q ? rdata : {WORD_SIZE{1'bz}};

`ifdef MEM_BUS_CHECK_EN
   logic                 bus_err_d, bus_err_q;
   logic                 addr_moved;
   logic                 addr_hi_set;

   assign addr_moved  = (address != WORD_SIZE'(addr_q));
   assign addr_hi_set = ((address >> ADDR_BITS) != '0);

   // Sticky protocol checker; flags stay set until reset.
   always_comb begin
      bus_err_d = bus_err_q;
      unique case (state_q)
         StIdle: begin
            if ((bus.readM & bus.writeM) | (one_req & addr_hi_set)) begin
               bus_err_d = 1'b1;
            end
         end
         StWait: begin
            if (!any_req | addr_moved) begin
               bus_err_d = 1'b1;
            end
         end
         StResp: begin
            if (addr_moved) begin
               bus_err_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Error flag register.
   always_ff @(posedge Clk) begin
      if (!Reset_N) begin
         bus_err_q <= 1'b0;
      end else begin
         bus_err_q <= bus_err_d;
      end
   end

   assign bus.bus_err = bus_err_q;
`else
   // Upper address bits only matter to the checker.
   logic unused_addr_hi;
   assign unused_addr_hi = ^address[WORD_SIZE-1:ADDR_BITS];
   assign bus.bus_err    = 1'b0;
`endif

endmodule
